ic74hc153: RTL and testbench

IC74HC153 -- requirements
Module: ic74hc153

---
 rtl/ic74hc153_pkg.sv | 11 +
 rtl/ic74hc153_if.sv | 23 ++
 rtl/ic74hc153_ch.sv | 40 ++++
 rtl/ic74hc153.sv | 43 ++++
 tb/tb_ic74hc153.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/ic74hc153_pkg.sv
// Shared constants and types for the dual 4:1 mux.
// Mux coding selectors and the 2-bit select type.
package ic74hc153_pkg;

    localparam int IMPL_GATE  = 0;
    localparam int IMPL_CASE  = 1;
    localparam int IMPL_INDEX = 2;

    typedef logic [1:0] sel_t;

endpackage

// File: rtl/ic74hc153_if.sv
// Bundle of the mux data, select, strobe and output nets.
// The master drives data/select/strobe; the slave returns y and y_q.
interface ic74hc153_if;
    import ic74hc153_pkg::*;

    logic [3:0] d1;
    logic [3:0] d2;
    sel_t       a;
    logic [1:0] s;
    logic [1:0] y;
    logic [1:0] y_q;

    modport master (
        output d1, d2, a, s,
        input  y, y_q
    );

    modport slave (
        input  d1, d2, a, s,
        output y, y_q
    );

endinterface

// File: rtl/ic74hc153_ch.sv
// One 4:1 mux channel with an active-low strobe.
// IMPL picks the coding; every coding gives the same function.
module ic74hc153_ch
    import ic74hc153_pkg::*;
#(
    parameter int IMPL = IMPL_GATE
) (
    input  logic [3:0] d,
    input  sel_t       a,
    input  logic       s_n,
    output logic       y
);

    if (IMPL == IMPL_GATE) begin : g_gate
        assign y = ~s_n & (
            (d[0] & ~a[1] & ~a[0]) |
            (d[1] & ~a[1] &  a[0]) |
            (d[2] &  a[1] & ~a[0]) |
            (d[3] &  a[1] &  a[0]));
    end else if (IMPL == IMPL_CASE) begin : g_case
        always_comb begin
            y = 1'b0;
            if (!s_n) begin
                case (a)
                    2'd0:    y = d[0];
                    2'd1:    y = d[1];
                    2'd2:    y = d[2];
                    2'd3:    y = d[3];
                    default: y = 1'b0;
                endcase
            end
        end
    end else if (IMPL == IMPL_INDEX) begin : g_index
        assign y = ~s_n & d[a];
    end else begin : g_bad
        $error("ic74hc153_ch: unsupported IMPL value %0d", IMPL);
        assign y = 1'b0;
    end

endmodule

// File: rtl/ic74hc153.sv
// Dual 4:1 mux with shared select, per-channel strobes
// and a registered copy of the outputs.
module ic74hc153
    import ic74hc153_pkg::*;
#(
    parameter int         IMPL      = IMPL_GATE,
    parameter logic [1:0] RESET_Y_Q = 2'b00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  sel_t       a,
    input  logic [1:0] s,
    output logic [1:0] y,
    output logic [1:0] y_q
);

    logic [1:0] y_d;

    ic74hc153_ch #(.IMPL(IMPL)) u_ch1 (
        .d   (d1),
        .a   (a),
        .s_n (s[0]),
        .y   (y[0])
    );

    ic74hc153_ch #(.IMPL(IMPL)) u_ch2 (
        .d   (d2),
        .a   (a),
        .s_n (s[1]),
        .y   (y[1])
    );

    assign y_d = y;

    // Deassertion is assumed clock-aligned upstream; no synchronizer here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) y_q <= RESET_Y_Q;
        else        y_q <= y_d;
    end

endmodule

// File: tb/tb_ic74hc153.sv
// Directed and sweep bench for the dual 4:1 mux, all three codings.
// A bit-shift model predicts y; a clocked model predicts y_q.
module tb_ic74hc153;
    import ic74hc153_pkg::*;

    localparam logic [1:0] RST = 2'b10;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    ic74hc153_if bus ();

    logic [1:0] y1, y2, yq1, yq2;
    logic [1:0] m_q;
    int  n_vec  = 0;
    int  n_bad  = 0;
    bit  cmp_en = 1'b0;

    always #5 clk = ~clk;

    ic74hc153 #(.IMPL(IMPL_GATE), .RESET_Y_Q(RST)) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .d1    (bus.d1),
        .d2    (bus.d2),
        .a     (bus.a),
        .s     (bus.s),
        .y     (bus.y),
        .y_q   (bus.y_q)
    );

    ic74hc153 #(.IMPL(IMPL_CASE), .RESET_Y_Q(RST)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .d1    (bus.d1),
        .d2    (bus.d2),
        .a     (bus.a),
        .s     (bus.s),
        .y     (y1),
        .y_q   (yq1)
    );

    ic74hc153 #(.IMPL(IMPL_INDEX), .RESET_Y_Q(RST)) u2 (
        .clk   (clk),
        .rst_n (rst_n),
        .d1    (bus.d1),
        .d2    (bus.d2),
        .a     (bus.a),
        .s     (bus.s),
        .y     (y2),
        .y_q   (yq2)
    );

    function automatic logic [1:0] model_y(
        logic [3:0] d1, logic [3:0] d2,
        logic [1:0] a,  logic [1:0] s);
        int sel;
        int b1, b2;
        sel = int'(a);
        b1  = (int'(d1) >> sel) % 2;
        b2  = (int'(d2) >> sel) % 2;
        if (s[0]) b1 = 0;
        if (s[1]) b2 = 0;
        return 2'(b2 * 2 + b1);
    endfunction

    function automatic logic [1:0] cur_y();
        return model_y(bus.d1, bus.d2, bus.a, bus.s);
    endfunction

    task automatic chk(string nm, logic [1:0] act, logic [1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic drive(logic [11:0] v);
        {bus.d1, bus.d2, bus.a, bus.s} = v;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_q <= RST;
        else        m_q <= cur_y();
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("y_gate",   bus.y,   cur_y());
            chk("y_case",   y1,      cur_y());
            chk("y_index",  y2,      cur_y());
            chk("yq_gate",  bus.y_q, m_q);
            chk("yq_case",  yq1,     m_q);
            chk("yq_index", yq2,     m_q);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] sel_exp [4];
        sel_exp = '{2'b10, 2'b01, 2'b10, 2'b01};

        drive(12'h000);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_yq0", bus.y_q, RST);
        chk("rst_yq1", yq1, RST);
        chk("rst_yq2", yq2, RST);
        chk("rst_y",   bus.y, 2'b00);

        step();
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        step();
        chk("rel_yq", bus.y_q, 2'b00);

        for (int i = 0; i < 4; i++) begin
            step();
            drive({4'b1010, 4'b0101, 2'(i), 2'b00});
            #1 chk($sformatf("sel_a%0d", i), bus.y, sel_exp[i]);
        end

        step();
        drive({4'hF, 4'hF, 2'd2, 2'b01});
        #1 chk("strobe_01", bus.y, 2'b10);
        step();
        drive({4'hF, 4'hF, 2'd2, 2'b10});
        #1 chk("strobe_10", bus.y, 2'b01);
        step();
        drive({4'hF, 4'hF, 2'd2, 2'b11});
        #1 chk("strobe_11", bus.y, 2'b00);

        step();
        drive({4'h0, 4'h0, 2'd0, 2'b00});
        step();
        chk("lat_yq_pre", bus.y_q, 2'b00);
        drive({4'hF, 4'hF, 2'd0, 2'b00});
        #1;
        chk("lat_y_now", bus.y, 2'b11);
        chk("lat_yq_old", bus.y_q, 2'b00);
        @(posedge clk);
        #1 chk("lat_yq_new", bus.y_q, 2'b11);

        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_yq0", bus.y_q, RST);
        chk("mid_rst_yq1", yq1, RST);
        chk("mid_rst_yq2", yq2, RST);
        chk("mid_rst_y",   bus.y, 2'b11);
        step();
        chk("rst_hold", bus.y_q, RST);
        rst_n = 1'b1;
        step();
        chk("rst_rel", bus.y_q, 2'b11);

        for (int i = 0; i < 16; i++) begin
            step();
            drive(12'($urandom_range(0, 4095)));
        end

        for (int v = 0; v < 4096; v++) begin
            step();
            drive(12'(v));
        end

        step();
        step();
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
